// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the MEM stage / camera writer and the shared data-memory port.
// The slave modport is the arbiter's view; master is the surrounding system.
interface mem_port_arbiter_if #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned FIFO_DEPTH = 4
);
    localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;

    logic              cpu_req;
    logic              cpu_we;
    logic [DATA_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_stall;
    logic              cam_valid;
    logic [DATA_W-1:0] cam_addr;
    logic [DATA_W-1:0] cam_data;
    logic              cam_ready;
    logic [DATA_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_we;
    logic [DATA_W-1:0] mem_rdata;
    logic              grant_cam;
    logic [CntW-1:0]   fifo_count;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata, cam_valid, cam_addr, cam_data, mem_rdata,
        output cpu_rdata, cpu_stall, cam_ready, mem_addr, mem_wdata, mem_we, grant_cam,
        fifo_count
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata, cam_valid, cam_addr, cam_data, mem_rdata,
        input  cpu_rdata, cpu_stall, cam_ready, mem_addr, mem_wdata, mem_we, grant_cam,
        fifo_count
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Single-port data memory arbiter: CPU MEM stage has priority, camera pixel writes are
// buffered in a FIFO and drained in idle cycles, on starvation, or in high-watermark drain.
module mem_port_arbiter #(
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter int unsigned STARVE_LIMIT = 8,
    parameter int unsigned DATA_W       = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    mem_port_arbiter_if.slave     bus
);
    localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned StvW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CntW-1:0] Full      = CntW'(FIFO_DEPTH);
    localparam logic [CntW-1:0] Half      = CntW'(FIFO_DEPTH / 2);
    localparam logic [StvW-1:0] StarveMax = StvW'(STARVE_LIMIT);

    typedef enum logic [0:0] {StNormal, StDrain} state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   count_q, count_d;
    logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [StvW-1:0]   starve_q, starve_d;
    logic [DATA_W-1:0] addr_mem_q [FIFO_DEPTH];
    logic [DATA_W-1:0] data_mem_q [FIFO_DEPTH];

    logic cam_ready;
    logic grant_cam;
    logic push;
    logic pop;

    always_comb begin
        // Ready looks only at the registered count, so a same-cycle pop never frees a slot.
        cam_ready = reset & (count_q < Full);
        grant_cam = (count_q != '0) &
                    ((state_q == StDrain) | ~bus.cpu_req | (starve_q == StarveMax));
        push      = bus.cam_valid & cam_ready;
        pop       = grant_cam;

        count_d = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase

        wr_ptr_d = push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PtrW'(1) : rd_ptr_q;

        starve_d = starve_q;
        if ((count_q == '0) || grant_cam) begin
            starve_d = '0;
        end else if (starve_q != StarveMax) begin
            starve_d = starve_q + StvW'(1);
        end

        state_d = state_q;
        unique case (state_q)
            StNormal: if (count_d == Full) state_d = StDrain;
            StDrain:  if (count_d <= Half) state_d = StNormal;
            default:  state_d = StNormal;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= StNormal;
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            starve_q <= '0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            starve_q <= starve_d;
        end
    end

    // Payload storage needs no reset: occupancy alone decides what is valid.
    always_ff @(posedge clock) begin
        if (push) begin
            addr_mem_q[wr_ptr_q] <= bus.cam_addr;
            data_mem_q[wr_ptr_q] <= bus.cam_data;
        end
    end

    assign bus.cam_ready  = cam_ready;
    assign bus.grant_cam  = grant_cam;
    assign bus.cpu_stall  = bus.cpu_req & grant_cam;
    assign bus.fifo_count = count_q;
    assign bus.cpu_rdata  = bus.mem_rdata;
    assign bus.mem_we     = reset & (grant_cam | (bus.cpu_req & bus.cpu_we));
    assign bus.mem_addr   = !reset   ? '0 :
                            grant_cam ? addr_mem_q[rd_ptr_q] : bus.cpu_addr;
    assign bus.mem_wdata  = !reset   ? '0 :
                            grant_cam ? data_mem_q[rd_ptr_q] : bus.cpu_wdata;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter against a queue-based reference model,
// plus directed scenarios for starvation, drain mode and mid-operation reset.
module tb_mem_port_arbiter;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned LIMIT = 8;
    localparam int unsigned DW    = 32;

    typedef struct {
        logic [DW-1:0] a;
        logic [DW-1:0] d;
    } pix_t;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    mem_port_arbiter_if #(.DATA_W(DW), .FIFO_DEPTH(DEPTH)) bus_if ();

    mem_port_arbiter #(
        .FIFO_DEPTH  (DEPTH),
        .STARVE_LIMIT(LIMIT),
        .DATA_W      (DW)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus_if)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: pixel queue, starvation counter, drain flag.
    pix_t q[$];
    int   starve = 0;
    bit   drain  = 1'b0;
    bit   m_gcam;

    logic          s_stall, s_gcam, s_ready, s_we;
    logic [DW-1:0] s_maddr, s_mdata;
    int            s_cnt;

    task automatic check_eq(input string tag, input logic [DW-1:0] got,
                            input logic [DW-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        q.delete();
        starve = 0;
        drain  = 1'b0;
    endtask

    task automatic check_outputs();
        int            cnt;
        logic          e_ready, e_we;
        logic [DW-1:0] e_addr, e_data;
        cnt     = q.size();
        m_gcam  = reset && cnt > 0 && (drain || !bus_if.cpu_req || starve == LIMIT);
        e_ready = reset && cnt < DEPTH;
        e_we    = reset && (m_gcam || (bus_if.cpu_req && bus_if.cpu_we));
        if (!reset) begin
            e_addr = '0;
            e_data = '0;
        end else if (m_gcam) begin
            e_addr = q[0].a;
            e_data = q[0].d;
        end else begin
            e_addr = bus_if.cpu_addr;
            e_data = bus_if.cpu_wdata;
        end
        check_eq("fifo_count", DW'(bus_if.fifo_count), DW'(cnt));
        check_eq("cam_ready", DW'(bus_if.cam_ready), DW'(e_ready));
        check_eq("grant_cam", DW'(bus_if.grant_cam), DW'(m_gcam));
        check_eq("cpu_stall", DW'(bus_if.cpu_stall), DW'(bus_if.cpu_req && m_gcam));
        check_eq("mem_we", DW'(bus_if.mem_we), DW'(e_we));
        check_eq("mem_addr", bus_if.mem_addr, e_addr);
        check_eq("mem_wdata", bus_if.mem_wdata, e_data);
        check_eq("cpu_rdata", bus_if.cpu_rdata, bus_if.mem_rdata);
        s_stall = bus_if.cpu_stall;
        s_gcam  = bus_if.grant_cam;
        s_ready = bus_if.cam_ready;
        s_we    = bus_if.mem_we;
        s_maddr = bus_if.mem_addr;
        s_mdata = bus_if.mem_wdata;
        s_cnt   = int'(bus_if.fifo_count);
    endtask

    task automatic update_model();
        int   cnt;
        pix_t p;
        if (!reset) begin
            model_clear();
            return;
        end
        cnt = q.size();
        if (cnt == 0 || m_gcam) starve = 0;
        else if (starve < LIMIT) starve++;
        if (m_gcam) void'(q.pop_front());
        if (bus_if.cam_valid && cnt < DEPTH) begin
            p.a = bus_if.cam_addr;
            p.d = bus_if.cam_data;
            q.push_back(p);
        end
        if (!drain && q.size() == DEPTH) drain = 1'b1;
        else if (drain && q.size() <= DEPTH / 2) drain = 1'b0;
    endtask

    task automatic step(input logic req, input logic we, input logic [DW-1:0] addr,
                        input logic [DW-1:0] wdata, input logic cv,
                        input logic [DW-1:0] caddr, input logic [DW-1:0] cdata);
        @(negedge clock);
        bus_if.cpu_req   = req;
        bus_if.cpu_we    = we;
        bus_if.cpu_addr  = addr;
        bus_if.cpu_wdata = wdata;
        bus_if.cam_valid = cv;
        bus_if.cam_addr  = caddr;
        bus_if.cam_data  = cdata;
        bus_if.mem_rdata = $urandom;
        #1;
        check_outputs();
        @(posedge clock);
        update_model();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, '0, 1'b0, '0, '0);
    endtask

    initial begin
        logic          r_req, r_we, r_cv;
        logic [DW-1:0] r_addr, r_wdata;

        bus_if.cpu_req   = 1'b0;
        bus_if.cpu_we    = 1'b0;
        bus_if.cpu_addr  = '0;
        bus_if.cpu_wdata = '0;
        bus_if.cam_valid = 1'b0;
        bus_if.cam_addr  = '0;
        bus_if.cam_data  = '0;
        bus_if.mem_rdata = '0;
        model_clear();

        // Reset, then release with no requests.
        idle(2);
        #1 reset = 1'b1;
        idle(1);
        check_eq("rst_ready", DW'(s_ready), 1);
        check_eq("rst_count", DW'(s_cnt), 0);
        check_eq("rst_we", DW'(s_we), 0);
        check_eq("rst_stall", DW'(s_stall), 0);

        // Idle CPU: three pixels each written the cycle after their push.
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b0, 32'h40, '0, i < 3, 32'h100 + DW'(i), 32'hA0 + DW'(i));
            if (i > 0) begin
                check_eq("cam_wr_addr", s_maddr, 32'h100 + DW'(i - 1));
                check_eq("cam_wr_we", DW'(s_we), 1);
                check_eq("cam_peak_cnt", DW'(s_cnt), 1);
            end
        end

        // Busy CPU, one pixel: forced grant on the ninth cycle after the push.
        step(1'b1, 1'b0, 32'h200, '0, 1'b1, 32'h300, 32'hBEEF);
        for (int k = 1; k <= 10; k++) begin
            step(1'b1, 1'b0, 32'h200, '0, 1'b0, '0, '0);
            check_eq($sformatf("starve_stall_%0d", k), DW'(s_stall), DW'(k == 9));
            if (k == 9) check_eq("starve_addr", s_maddr, 32'h300);
        end

        // Busy CPU, four pixels back-to-back: drain mode, refused push on full.
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 32'h210, 32'h5, 1'b1, 32'h400 + DW'(i), DW'(i));
        step(1'b1, 1'b1, 32'h210, 32'h5, 1'b1, 32'h4FF, 32'hDEAD);
        check_eq("full_ready", DW'(s_ready), 0);
        check_eq("drain_stall1", DW'(s_stall), 1);
        check_eq("full_count", DW'(s_cnt), 4);
        step(1'b1, 1'b1, 32'h210, 32'h5, 1'b0, '0, '0);
        check_eq("after_pop_ready", DW'(s_ready), 1);
        check_eq("after_pop_count", DW'(s_cnt), 3);
        check_eq("drain_stall2", DW'(s_stall), 1);
        step(1'b1, 1'b1, 32'h210, 32'h5, 1'b0, '0, '0);
        check_eq("normal_stall", DW'(s_stall), 0);
        check_eq("normal_count", DW'(s_cnt), 2);
        idle(3);

        // Reset mid-drain with count 3.
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 32'h220, 32'h6, 1'b1, 32'h500 + DW'(i), DW'(i));
        step(1'b1, 1'b1, 32'h220, 32'h6, 1'b0, '0, '0);
        #2 reset = 1'b0;
        #1;
        model_clear();
        check_eq("mid_rst_count", DW'(bus_if.fifo_count), 0);
        check_eq("mid_rst_we", DW'(bus_if.mem_we), 0);
        check_eq("mid_rst_grant", DW'(bus_if.grant_cam), 0);
        check_eq("mid_rst_addr", bus_if.mem_addr, 0);
        step(1'b1, 1'b1, 32'h220, 32'h6, 1'b1, 32'h600, 32'h1);
        #1 reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 32'h0, '0, 1'b0, '0, '0);
            check_eq("no_stale_we", DW'(s_we), 0);
        end

        // Randomized traffic; a stalled CPU holds its request stable.
        r_req = 1'b0; r_we = 1'b0; r_addr = '0; r_wdata = '0;
        for (int c = 0; c < 1500; c++) begin
            if (!s_stall) begin
                r_req   = ($urandom_range(0, 9) < 7);
                r_we    = $urandom_range(0, 1) == 1;
                r_addr  = $urandom;
                r_wdata = $urandom;
            end
            r_cv = ($urandom_range(0, 9) < ((c / 250) % 2 == 0 ? 4 : 8));
            step(r_req, r_we, r_addr, r_wdata, r_cv, $urandom, $urandom);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-port data memory between the MEM pipeline stage and the camera pixel writer.
- Camera writes are buffered in an internal FIFO and drained into memory in cycles the CPU does not use.
- The CPU has priority, except for a starvation limit and a high-watermark drain mode; when the camera holds the port, the pipeline is stalled.
- Sits between the MEM stage (ALUOutM/WriteDataM/MemWrite) and the data memory.

Parameters:
- FIFO_DEPTH, 4, camera write FIFO entries (power of two, >=2).
- STARVE_LIMIT, 8, consecutive cycles a non-empty FIFO may be denied before a forced camera grant.
- DATA_W, 32, address and data width.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- cpu_req  in  1  MEM stage needs memory this cycle (load or store).
- cpu_we  in  1  MEM stage store (MemWriteM).
- cpu_addr  in  DATA_W  ALUOutM.
- cpu_wdata  in  DATA_W  store data (after PlusOne mux).
- cpu_rdata  out  DATA_W  read data to the MEM/WB register (mem_rdata passthrough).
- cpu_stall  out  1  hold IF..MEM and bubble WB this cycle.
- cam_valid  in  1  camera pixel write offered.
- cam_addr  in  DATA_W  pixel address.
- cam_data  in  DATA_W  pixel data.
- cam_ready  out  1  FIFO accepts the offered write this cycle.
- mem_addr  out  DATA_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_we  out  1  memory write enable.
- mem_rdata  in  DATA_W  combinational memory read data.
- grant_cam  out  1  camera owns the port this cycle.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (reset=0, async): FIFO emptied, fifo_count=0, starve_cnt=0, state=NORMAL.
  - While reset is low: cam_ready=0, cpu_stall=0, grant_cam=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - Reset mid-operation discards all buffered pixels. No memory write is issued after reset assertion.
- FIFO:
  - cam_ready = (fifo_count < FIFO_DEPTH), derived from registered count only.
  - A pop in the same cycle does not raise ready early.
  - Push on cam_valid & cam_ready.
  - Pop when grant_cam=1.
  - Simultaneous push and pop: count unchanged; entry order preserved.
  - Pointers wrap modulo FIFO_DEPTH.
- Port grant is combinational from current state, count and cpu_req:
  - grant_cam = (count>0) & (state==DRAIN | !cpu_req | starve_cnt==STARVE_LIMIT).
  - cpu_stall = cpu_req & grant_cam.
- Memory mux:
  - grant_cam=1: mem_addr/mem_wdata = FIFO head, mem_we=1.
  - Else: mem_addr=cpu_addr, mem_wdata=cpu_wdata, mem_we=cpu_req&cpu_we.
  - No request at all: mem_we=0; address and data follow the CPU inputs.
- cpu_rdata = mem_rdata at all times; it is meaningful only when cpu_stall=0.
- starve_cnt (saturating at STARVE_LIMIT):
  - Cleared on any grant_cam.
  - Incremented when count>0 and cpu_req holds the port.
  - Cleared when count==0.
- State machine:
  - NORMAL -> DRAIN when the next count equals FIFO_DEPTH.
  - DRAIN -> NORMAL when the next count <= FIFO_DEPTH/2.
  - DRAIN stalls the CPU on every cycle it requests.
- Latency:
  - A pushed pixel can be written no earlier than the next cycle.
  - A CPU access completes in the cycle cpu_stall=0.
  - A stalled CPU must hold cpu_req/addr/data stable.
- Ordering: camera and CPU address hazards are not checked; software separates frame buffer and data regions.

Test Plan:
- Reset release, no requests -> cam_ready=1, fifo_count=0, mem_we=0, cpu_stall=0.
- cpu_req=0, push 3 pixels (addr 0x100..0x102) on consecutive cycles -> each written one cycle after its push, in order; fifo_count peaks at 1.
- cpu_req=1 continuously, one pixel pushed -> cpu_stall=0 for 8 cycles, then forced grant_cam on cycle 9 with cpu_stall=1; pixel written; next cycle cpu_stall=0.
- cpu_req=1 continuously, 4 pixels pushed back-to-back -> count reaches 4, cam_ready=0, DRAIN entered.
  - cpu_stall=1 for 2 drain cycles until count=2, then NORMAL.
- Push on the same cycle as a forced pop with count=4 -> push refused (cam_ready=0); count becomes 3; next cycle cam_ready=1.
- Assert reset low with count=3 mid-drain -> outputs go to reset values immediately; after release count=0 and no stale write appears.
